// File: rtl/alien_laser_ctrl_pkg.sv
// Shared game constants and helpers for the alien laser controller.
// Covers screen geometry, laser/alien sizes, parking position, colour and slot state.
package alien_laser_ctrl_pkg;

    localparam int NUM_ALIEN_LASERS = 3;

    localparam logic [9:0] SCREEN_LEFT   = 10'd0;
    localparam logic [9:0] SCREEN_RIGHT  = 10'd639;
    localparam logic [9:0] SCREEN_TOP    = 10'd0;
    localparam logic [9:0] SCREEN_BOTTOM = 10'd479;

    localparam logic [9:0] LASER_HALF_H = 10'd5;
    localparam logic [9:0] LASER_HALF_W = 10'd1;
    localparam logic [9:0] ALIEN_HALF_H = 10'd8;

    // Parked lasers sit off-screen so they can never overlap the ship hit window.
    localparam logic [9:0] PARK_X = 10'd1000;
    localparam logic [9:0] PARK_Y = 10'd0;

    localparam logic [7:0] COLOR_ALIEN_LASER = 8'b00111111;
    localparam logic [7:0] COLOR_NONE        = 8'h00;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } slot_state_e;

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [9:0] pick10(input logic [29:0] bus, input logic [1:0] idx);
        case (idx)
            2'd0:    pick10 = bus[9:0];
            2'd1:    pick10 = bus[19:10];
            2'd2:    pick10 = bus[29:20];
            default: pick10 = bus[9:0];
        endcase
    endfunction

endpackage

// File: rtl/alien_laser_ctrl_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that advances only when stepped.
// Loads the seed on reset; holds its value otherwise.
module lfsr8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_step,
    input  logic [7:0] i_seed,
    output logic [7:0] o_value
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Shift register: reseed on reset, shift in feedback on step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= i_seed;
        end else if (i_step) begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end else begin
            r_lfsr <= r_lfsr;
        end
    end

    assign o_value = r_lfsr;

endmodule

// File: rtl/alien_laser_ctrl.sv
// Alien laser controller: fires up to three lasers from live aliens and animates them per frame.
// Optional ALIEN_LASER_AIM_EN picks the alien closest in x to the ship instead of the LFSR choice.
module alien_laser_ctrl
    import alien_laser_ctrl_pkg::*;
#(
    parameter int         FIRE_PERIOD  = 60,
    parameter int         LASER_SPEED  = 2,
    parameter logic [7:0] LFSR_SEED    = 8'hA5,
    parameter int         BOTTOM_LIMIT = 470
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode,
    input  logic [9:0]  xCoord,
    input  logic [9:0]  yCoord,
    input  logic [29:0] alien_xCoord,
    input  logic [29:0] alien_yCoord,
    input  logic [2:0]  alien_alive,
    input  logic [2:0]  barr_alien_laser_hit,
    input  logic [9:0]  spaceship_xCoord,
    output logic [29:0] alien_laser_xCoord,
    output logic [29:0] alien_laser_yCoord,
    output logic [7:0]  rgb,
    output logic        is_alien_laser
);

    localparam logic [15:0] FIRE_LAST = 16'(FIRE_PERIOD - 1);
    localparam logic [9:0]  SPEED     = 10'(LASER_SPEED);
    localparam logic [9:0]  BOTTOM_Y  = 10'(BOTTOM_LIMIT);

    slot_state_e r_state     [NUM_ALIEN_LASERS];
    logic [9:0]  r_x         [NUM_ALIEN_LASERS];
    logic [9:0]  r_y         [NUM_ALIEN_LASERS];
    slot_state_e w_state_nxt [NUM_ALIEN_LASERS];
    logic [9:0]  w_x_nxt     [NUM_ALIEN_LASERS];
    logic [9:0]  w_y_nxt     [NUM_ALIEN_LASERS];

    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        w_tick;
    logic        w_fire;
    logic [7:0]  w_lfsr;
    logic [1:0]  w_shooter;
    logic        w_shooter_ok;
    logic        w_has_idle;
    logic [1:0]  w_tgt;
    logic        w_spawn;
    logic [9:0]  w_spawn_x;
    logic [9:0]  w_spawn_y;
    logic        w_px_hit;
    logic        w_unused;

    assign w_tick = (xCoord == 10'd0) && (yCoord == 10'd0);

    lfsr8 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_step  (mode & w_tick),
        .i_seed  (LFSR_SEED),
        .o_value (w_lfsr)
    );

    assign w_unused = ^{spaceship_xCoord, w_lfsr};

    // Frame counter: a fire attempt happens on the tick where the counter wraps.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_fire    = 1'b0;
        if (!mode) begin
            w_cnt_nxt = 16'd0;
        end else if (w_tick) begin
            if (r_cnt == FIRE_LAST) begin
                w_cnt_nxt = 16'd0;
                w_fire    = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 16'd1;
            end
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

`ifdef ALIEN_LASER_AIM_EN
    logic [9:0] w_best;

    // Shooter is the live alien nearest the ship in x; strict compare keeps the lowest index on ties.
    always_comb begin
        w_shooter    = 2'd0;
        w_shooter_ok = 1'b0;
        w_best       = 10'h3FF;
        for (int i = 0; i < NUM_ALIEN_LASERS; i++) begin
            if (alien_alive[i] &&
                (!w_shooter_ok || (abs_diff(pick10(alien_xCoord, 2'(i)), spaceship_xCoord) < w_best))) begin
                w_shooter    = 2'(i);
                w_shooter_ok = 1'b1;
                w_best       = abs_diff(pick10(alien_xCoord, 2'(i)), spaceship_xCoord);
            end else begin
                w_best = w_best;
            end
        end
    end
`else
    // Shooter comes from the low LFSR bits, folding the unused code 3 onto alien 0.
    always_comb begin
        w_shooter    = (w_lfsr[1:0] == 2'd3) ? 2'd0 : w_lfsr[1:0];
        w_shooter_ok = alien_alive[w_shooter];
    end
`endif

    // Target is the lowest-index IDLE slot as seen before this edge.
    always_comb begin
        w_has_idle = 1'b0;
        w_tgt      = 2'd0;
        for (int i = NUM_ALIEN_LASERS - 1; i >= 0; i--) begin
            if (r_state[i] == IDLE) begin
                w_has_idle = 1'b1;
                w_tgt      = 2'(i);
            end else begin
                w_tgt = w_tgt;
            end
        end
    end

    assign w_spawn   = w_fire && w_has_idle && w_shooter_ok;
    assign w_spawn_x = pick10(alien_xCoord, w_shooter);
    assign w_spawn_y = pick10(alien_yCoord, w_shooter) + ALIEN_HALF_H + LASER_HALF_H;

    // Per-slot next state: mode drop parks all, barrier hit beats motion, spawns fill IDLE slots.
    always_comb begin
        for (int i = 0; i < NUM_ALIEN_LASERS; i++) begin
            w_state_nxt[i] = r_state[i];
            w_x_nxt[i]     = r_x[i];
            w_y_nxt[i]     = r_y[i];
            if (!mode) begin
                w_state_nxt[i] = IDLE;
                w_x_nxt[i]     = PARK_X;
                w_y_nxt[i]     = PARK_Y;
            end else begin
                case (r_state[i])
                    ACTIVE: begin
                        if (barr_alien_laser_hit[i]) begin
                            w_state_nxt[i] = IDLE;
                            w_x_nxt[i]     = PARK_X;
                            w_y_nxt[i]     = PARK_Y;
                        end else if (w_tick) begin
                            if ((r_y[i] + SPEED) >= BOTTOM_Y) begin
                                w_state_nxt[i] = IDLE;
                                w_x_nxt[i]     = PARK_X;
                                w_y_nxt[i]     = PARK_Y;
                            end else begin
                                w_y_nxt[i] = r_y[i] + SPEED;
                            end
                        end else begin
                            w_y_nxt[i] = r_y[i];
                        end
                    end
                    IDLE: begin
                        if (w_spawn && (w_tgt == 2'(i))) begin
                            w_state_nxt[i] = ACTIVE;
                            w_x_nxt[i]     = w_spawn_x;
                            w_y_nxt[i]     = w_spawn_y;
                        end else begin
                            w_state_nxt[i] = IDLE;
                        end
                    end
                    default: begin
                        w_state_nxt[i] = IDLE;
                        w_x_nxt[i]     = PARK_X;
                        w_y_nxt[i]     = PARK_Y;
                    end
                endcase
            end
        end
    end

    // Slot and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
            for (int i = 0; i < NUM_ALIEN_LASERS; i++) begin
                r_state[i] <= IDLE;
                r_x[i]     <= PARK_X;
                r_y[i]     <= PARK_Y;
            end
        end else begin
            r_cnt <= w_cnt_nxt;
            for (int i = 0; i < NUM_ALIEN_LASERS; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_x[i]     <= w_x_nxt[i];
                r_y[i]     <= w_y_nxt[i];
            end
        end
    end

    // Pixel hit test uses absolute differences so no side can underflow.
    always_comb begin
        w_px_hit = 1'b0;
        for (int i = 0; i < NUM_ALIEN_LASERS; i++) begin
            if ((r_state[i] == ACTIVE) &&
                (abs_diff(yCoord, r_y[i]) <= LASER_HALF_H) &&
                (abs_diff(xCoord, r_x[i]) <= LASER_HALF_W)) begin
                w_px_hit = 1'b1;
            end else begin
                w_px_hit = w_px_hit;
            end
        end
    end

    assign is_alien_laser     = w_px_hit;
    assign rgb                = w_px_hit ? COLOR_ALIEN_LASER : COLOR_NONE;
    assign alien_laser_xCoord = {r_x[2], r_x[1], r_x[0]};
    assign alien_laser_yCoord = {r_y[2], r_y[1], r_y[0]};

endmodule

// File: tb/tb_alien_laser_ctrl.sv
// Self-checking bench for alien_laser_ctrl: scoreboarded slot outputs plus a pixel vector table.
module tb_alien_laser_ctrl;

    localparam int FP     = 4;
    localparam int SPEED  = 2;
    localparam int BOTTOM = 470;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [9:0]  xCoord;
    logic [9:0]  yCoord;
    logic [29:0] alien_xCoord;
    logic [29:0] alien_yCoord;
    logic [2:0]  alien_alive;
    logic [2:0]  barr_alien_laser_hit;
    logic [9:0]  spaceship_xCoord;
    logic [29:0] alien_laser_xCoord;
    logic [29:0] alien_laser_yCoord;
    logic [7:0]  rgb;
    logic        is_alien_laser;

    logic [9:0] ax [3];
    logic [9:0] ay [3];

    always #5 clk = ~clk;

    assign alien_xCoord = {ax[2], ax[1], ax[0]};
    assign alien_yCoord = {ay[2], ay[1], ay[0]};

    alien_laser_ctrl #(
        .FIRE_PERIOD  (FP),
        .LASER_SPEED  (SPEED),
        .LFSR_SEED    (8'hA5),
        .BOTTOM_LIMIT (BOTTOM)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .mode                 (mode),
        .xCoord               (xCoord),
        .yCoord               (yCoord),
        .alien_xCoord         (alien_xCoord),
        .alien_yCoord         (alien_yCoord),
        .alien_alive          (alien_alive),
        .barr_alien_laser_hit (barr_alien_laser_hit),
        .spaceship_xCoord     (spaceship_xCoord),
        .alien_laser_xCoord   (alien_laser_xCoord),
        .alien_laser_yCoord   (alien_laser_yCoord),
        .rgb                  (rgb),
        .is_alien_laser       (is_alien_laser)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int         mx [3];
    int         my [3];
    bit         mact [3];
    int         mcnt;
    logic [7:0] mlfsr;

    typedef struct {
        logic [29:0] x;
        logic [29:0] y;
    } exp_t;
    exp_t sb_q [$];

    typedef struct {
        int   dx;
        int   dy;
        logic hit;
    } px_vec_t;
    px_vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [29:0] pack3(input int a0, input int a1, input int a2);
        return {10'(a2), 10'(a1), 10'(a0)};
    endfunction

    function automatic logic [9:0] dut_x(input int i);
        return alien_laser_xCoord[10*i +: 10];
    endfunction

    function automatic logic [9:0] dut_y(input int i);
        return alien_laser_yCoord[10*i +: 10];
    endfunction

    task automatic model_park();
        for (int i = 0; i < 3; i++) begin
            mx[i]   = 1000;
            my[i]   = 0;
            mact[i] = 1'b0;
        end
    endtask

    task automatic model_step(input logic md, input logic tk, input logic [2:0] hit);
        int tgt;
        int s;
        bit fire;
        int nx [3];
        int ny [3];
        bit na [3];
        if (!md) begin
            model_park();
            mcnt = 0;
        end else begin
            fire = 1'b0;
            if (tk) begin
                if (mcnt == FP - 1) begin
                    fire = 1'b1;
                    mcnt = 0;
                end else begin
                    mcnt++;
                end
            end
            tgt = -1;
            for (int i = 0; i < 3; i++) if (!mact[i] && tgt < 0) tgt = i;
            s = (mlfsr[1:0] == 2'd3) ? 0 : int'(mlfsr[1:0]);
            nx = mx;
            ny = my;
            na = mact;
            for (int i = 0; i < 3; i++) begin
                if (mact[i]) begin
                    if (hit[i] || (tk && (my[i] + SPEED >= BOTTOM))) begin
                        nx[i] = 1000; ny[i] = 0; na[i] = 1'b0;
                    end else if (tk) begin
                        ny[i] = my[i] + SPEED;
                    end
                end
            end
            if (fire && tgt >= 0 && alien_alive[s]) begin
                na[tgt] = 1'b1;
                nx[tgt] = int'(ax[s]);
                ny[tgt] = int'(ay[s]) + 13;
            end
            mx   = nx;
            my   = ny;
            mact = na;
            if (tk) mlfsr = {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
        end
    endtask

    task automatic cycle(input logic [9:0] px, input logic [9:0] py, input logic [2:0] hit);
        exp_t e;
        xCoord               = px;
        yCoord               = py;
        barr_alien_laser_hit = hit;
        model_step(mode, (px == 10'd0) && (py == 10'd0), hit);
        sb_q.push_back('{pack3(mx[0], mx[1], mx[2]), pack3(my[0], my[1], my[2])});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("slot_x", {2'b00, alien_laser_xCoord}, {2'b00, e.x});
        check("slot_y", {2'b00, alien_laser_yCoord}, {2'b00, e.y});
        barr_alien_laser_hit = 3'b000;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) cycle(10'd0, 10'd0, 3'b000);
    endtask

    initial begin
        vecs[0]  = '{0, 0, 1'b1};
        vecs[1]  = '{1, 0, 1'b1};
        vecs[2]  = '{-1, 0, 1'b1};
        vecs[3]  = '{2, 0, 1'b0};
        vecs[4]  = '{-2, 0, 1'b0};
        vecs[5]  = '{0, 5, 1'b1};
        vecs[6]  = '{0, -5, 1'b1};
        vecs[7]  = '{0, 6, 1'b0};
        vecs[8]  = '{0, -6, 1'b0};
        vecs[9]  = '{1, -5, 1'b1};
        vecs[10] = '{-2, 5, 1'b0};
        vecs[11] = '{1, 6, 1'b0};

        rst_n                = 1'b0;
        mode                 = 1'b1;
        xCoord               = 10'd1000;
        yCoord               = 10'd0;
        alien_alive          = 3'b111;
        barr_alien_laser_hit = 3'b000;
        spaceship_xCoord     = 10'd320;
        ax[0] = 10'd100; ax[1] = 10'd200; ax[2] = 10'd300;
        ay[0] = 10'd150; ay[1] = 10'd150; ay[2] = 10'd150;
        model_park();
        mcnt  = 0;
        mlfsr = 8'hA5;

        // Reset state, probing the parked position as a pixel.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_x", {2'b00, alien_laser_xCoord}, {2'b00, pack3(1000, 1000, 1000)});
        check("reset_y", {2'b00, alien_laser_yCoord}, 32'd0);
        check("reset_is_laser", {31'd0, is_alien_laser}, 32'd0);
        check("reset_rgb", {24'd0, rgb}, 32'd0);
        rst_n = 1'b1;

        // Fire cadence: nothing before the 4th tick, then slot 0 spawns.
        ticks(3);
        check("no_early_spawn", {22'd0, dut_x(0)}, 32'd1000);
        ticks(1);
        check("spawn_y", {22'd0, dut_y(0)}, 32'd163);
        check("spawn_x", {22'd0, dut_x(0)}, 32'(mx[0]));
        check("slot1_idle", {22'd0, dut_x(1)}, 32'd1000);

        // Pixel table around the single active laser.
        for (int v = 0; v < 12; v++) begin
            xCoord = 10'(mx[0] + vecs[v].dx);
            yCoord = 10'(my[0] + vecs[v].dy);
            #1;
            check("pix_hit", {31'd0, is_alien_laser}, {31'd0, vecs[v].hit});
            check("pix_rgb", {24'd0, rgb}, vecs[v].hit ? 32'h3F : 32'h00);
            cycle(xCoord, yCoord, 3'b000);
        end

        // Motion: 10 ticks at speed 2.
        ticks(10);
        check("motion_y", {22'd0, dut_y(0)}, 32'd183);

        // Barrier hit mid-line on active slot 1, then on the now-idle slot.
        check("slot1_active", {31'd0, mact[1]}, 32'd1);
        cycle(10'd5, 10'd5, 3'b010);
        check("hit_parks_x", {22'd0, dut_x(1)}, 32'd1000);
        check("hit_parks_y", {22'd0, dut_y(1)}, 32'd0);
        check("hit_keeps_s0", {22'd0, dut_y(0)}, 32'd183);
        cycle(10'd5, 10'd5, 3'b010);
        check("hit_idle_s1", {22'd0, dut_x(1)}, 32'd1000);

        // Saturation then a freed slot to reveal the wrapped counter.
        ticks(6);
        cycle(10'd7, 10'd9, 3'b001);
        ticks(8);

        // Mode drop mid-flight, then a full period before the next fire.
        mode = 1'b0;
        cycle(10'd5, 10'd5, 3'b000);
        check("mode_park", {2'b00, alien_laser_xCoord}, {2'b00, pack3(1000, 1000, 1000)});
        mode = 1'b1;
        ticks(3);
        check("mode_no_early", {22'd0, dut_x(0)}, 32'd1000);
        ticks(1);
        check("mode_respawn_x", {22'd0, dut_x(0)}, 32'(mx[0]));
        ticks(4);

        // Dead shooters: no spawn ever.
        mode = 1'b0;
        cycle(10'd5, 10'd5, 3'b000);
        mode        = 1'b1;
        alien_alive = 3'b000;
        ticks(12);
        check("dead_no_spawn", {2'b00, alien_laser_xCoord}, {2'b00, pack3(1000, 1000, 1000)});

        // Bottom retire: spawn at y=468, next tick parks.
        mode = 1'b0;
        cycle(10'd5, 10'd5, 3'b000);
        mode        = 1'b1;
        alien_alive = 3'b111;
        ay[0] = 10'd455; ay[1] = 10'd455; ay[2] = 10'd455;
        ticks(4);
        check("near_bottom_y", {22'd0, dut_y(0)}, 32'd468);
        ticks(1);
        check("retire_x", {22'd0, dut_x(0)}, 32'd1000);
        check("retire_y", {22'd0, dut_y(0)}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alien_laser_ctrl.md
Name: alien_laser_ctrl

Overview:
- Generates and animates up to three alien lasers and fires them from live aliens at a pseudo-random, rate-limited cadence.
- Sits directly upstream of the player spaceship block. Its packed laser coordinates are that block's `alien_laser_xCoord` / `alien_laser_yCoord` inputs.
- Also supplies per-pixel colour and hit flags to the VGA colour mux.

Parameters:
- FIRE_PERIOD, 60, frame ticks between fire attempts (≥1)
- LASER_SPEED, 2, pixels moved down per frame tick
- LFSR_SEED, 8'hA5, LFSR value after reset (nonzero)
- BOTTOM_LIMIT, 470, laser retires when its y would reach this value

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- mode  in  1  0 = menu/idle (all parked), 1 = play
- xCoord  in  10  current VGA pixel x
- yCoord  in  10  current VGA pixel y
- alien_xCoord  in  30  packed centre x of aliens 0..2 (alien i in bits [10i+9:10i])
- alien_yCoord  in  30  packed centre y of aliens 0..2 (same packing)
- alien_alive  in  3  per-alien alive flag
- barr_alien_laser_hit  in  3  per-slot barrier-hit pulse
- spaceship_xCoord  in  10  ship centre x (used only with the optional feature)
- alien_laser_xCoord  out  30  packed laser centre x per slot
- alien_laser_yCoord  out  30  packed laser centre y per slot
- rgb  out  8  laser colour for the current pixel
- is_alien_laser  out  1  current pixel lies inside an active laser

Behaviour:
- Frame tick: `tick = (xCoord==0 && yCoord==0)`. All movement, firing and LFSR stepping occur only on tick cycles.
- Parked slot: x=1000, y=0. This is never inside the spaceship hit window.
- Reset (`rst_n`=0) or `mode`=0, at the clock edge:
  - all slots IDLE and parked;
  - frame counter = 0;
  - LFSR = LFSR_SEED (reset only; `mode`=0 leaves the LFSR unchanged).
- Per-slot FSM, IDLE ↔ ACTIVE:
  - IDLE→ACTIVE only via spawn.
  - ACTIVE→IDLE on barrier hit or bottom retire; the slot is parked in the same edge.
- Barrier hit:
  - `barr_alien_laser_hit[i]`=1 on any cycle retires ACTIVE slot i on that edge.
  - It takes priority over movement.
  - A hit pulse on an IDLE slot is ignored.
- Movement on tick, for each ACTIVE slot:
  - if y+LASER_SPEED ≥ BOTTOM_LIMIT → retire;
  - else y += LASER_SPEED, x unchanged.
- Frame counter:
  - increments on tick;
  - at FIRE_PERIOD−1 a fire attempt occurs and the counter wraps to 0.
- Fire attempt:
  - shooter index s = (lfsr[1:0]==3) ? 0 : lfsr[1:0];
  - target slot = lowest-index IDLE slot.
  - Shot is dropped if no slot is IDLE or `alien_alive[s]`=0. The counter still wraps.
  - Spawned slot: ACTIVE, x = alien x[s], y = alien y[s]+13 (alien half-height 8 + laser half-height 5).
  - A slot spawned on a tick does not move on that tick.
  - A slot retired on the same tick is not IDLE until the next edge, so it cannot be reused on that tick.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1;
  - steps once per tick, after use.
- Arithmetic: all coordinate arithmetic is 10-bit unsigned. The spawn y sum never exceeds 1023 for on-screen aliens.
- Pixel output, combinational:
  - `is_alien_laser` = OR over ACTIVE slots of (|yCoord−y| ≤ 5 && |xCoord−x| ≤ 1), evaluated without unsigned underflow;
  - `rgb` = 8'b00111111 when `is_alien_laser`, else 8'h00.
- All coordinate outputs are registered (one slot register per field).

Optional Feature:
- Macro: ALIEN_LASER_AIM_EN.
- Defined: shooter = the live alien with minimum |alien x − `spaceship_xCoord`|, ties to the lowest index. The LFSR still steps each tick but is unused. If no alien is alive, the shot is dropped.
- Undefined: LFSR selection as above; `spaceship_xCoord` is ignored.

Decomposition:
- Shared package (game constants):
  - screen edges;
  - laser half-sizes (5, 1);
  - alien half-height 8;
  - PARK_X/PARK_Y;
  - COLOR_ALIEN_LASER;
  - slot state enum {IDLE, ACTIVE};
  - NUM_ALIEN_LASERS=3.
- One sub-module: `lfsr8` (clk, rst_n, step, seed → 8-bit value).

Test Plan:
- Reset: `rst_n`=0 for 2 cycles, `mode`=1 → all slot x=1000, y=0; `is_alien_laser`=0; `rgb`=0.
- Fire cadence: FIRE_PERIOD=4, all alive, alien0 at (100,150), alien1 at (200,150), alien2 at (300,150) → first spawn on 4th tick in slot 0. Spawn x equals the model-predicted alien, y=163.
- Motion/retire: active slot at y=163, SPEED=2 → after 10 ticks y=183; preset y=468 → next tick parks (1000,0).
- Barrier hit: pulse `barr_alien_laser_hit`=3'b010 mid-line with slot 1 active → slot 1 parked next edge; slots 0 and 2 unchanged; pulse on an IDLE slot → no change.
- Saturation/dead shooter: all 3 slots active at a fire tick → no change, counter wraps. `alien_alive`=0 → no spawn ever.
- Mode drop: `mode`=0 mid-flight → all parked next edge. Return to `mode`=1 → first fire after a full FIRE_PERIOD; LFSR continues its sequence rather than reseeding.
